// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the RV32I integer ALU.
//   XLEN    - operand/result width (32 only)
//   SHAMT_W - shift amount width (log2 XLEN)
//   F3_*    - funct3 operation encodings
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// alu_shifter: combinational barrel shifter for SLL/SRL/SRA.
//   data   - value to shift
//   shamt  - shift amount
//   dir    - 0 = left, 1 = right
//   arith  - right shifts fill with data[MSB] when set, zero otherwise
//   result - shifted value
module alu_shifter
    import alu_pkg::*;
#(
    parameter int W       = XLEN,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic [W-1:0]       data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               arith,
    output logic [W-1:0]       result
);

    logic              fill;
    logic signed [W:0] ext_s;
    logic        [W:0] shr_w;
    logic      [W-1:0] shl_w;

    // One extra bit carries the fill value, so a single arithmetic shift
    // covers both SRL (fill=0) and SRA (fill=sign).
    assign fill   = arith & data[W-1];
    assign ext_s  = $signed({fill, data});
    assign shr_w  = ext_s >>> shamt;
    assign shl_w  = data << shamt;
    assign result = dir ? shr_w[W-1:0] : shl_w;

endmodule

// File: rtl/alu_core.sv
// alu_core: RV32I integer ALU with a registered result (1-cycle latency).
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset, clears aluout
//   aluin1 - operand A (rs1)
//   aluin2 - operand B (rs2 or sign-extended immediate)
//   funct3 - operation select
//   funct7 - instruction bit 30, selects SUB / SRA
//   aluout - registered result
module alu_core
    import alu_pkg::*;
#(
    parameter int XLEN    = alu_pkg::XLEN,
    parameter int SHAMT_W = alu_pkg::SHAMT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] aluin1,
    input  logic [XLEN-1:0] aluin2,
    input  logic [2:0]      funct3,
    input  logic            funct7,
    output logic [XLEN-1:0] aluout
);

    logic [XLEN-1:0] aluout_d, aluout_q;
    logic [XLEN-1:0] addsub;
    logic [XLEN-1:0] shift_res;
    logic            lt_s, lt_u;
    logic            shr_sel;

    assign addsub = funct7 ? (aluin1 - aluin2) : (aluin1 + aluin2);
    assign lt_s   = $signed(aluin1) < $signed(aluin2);
    assign lt_u   = aluin1 < aluin2;

    // Only the F3_SR encoding shifts right; funct7 then picks SRA over SRL.
    assign shr_sel = (funct3 == F3_SR);

    alu_shifter #(
        .W       (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .data   (aluin1),
        .shamt  (aluin2[SHAMT_W-1:0]),
        .dir    (shr_sel),
        .arith  (funct7),
        .result (shift_res)
    );

    // funct7 only reaches the ADD/SUB and shift paths, so an unknown
    // funct7 cannot disturb the logical and compare results.
    always_comb begin
        aluout_d = '0;
        case (funct3)
            F3_ADD:  aluout_d = addsub;
            F3_SLL:  aluout_d = shift_res;
            F3_SLT:  aluout_d = {{(XLEN-1){1'b0}}, lt_s};
            F3_SLTU: aluout_d = {{(XLEN-1){1'b0}}, lt_u};
            F3_XOR:  aluout_d = aluin1 ^ aluin2;
            F3_SR:   aluout_d = shift_res;
            F3_OR:   aluout_d = aluin1 | aluin2;
            F3_AND:  aluout_d = aluin1 & aluin2;
            default: aluout_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) aluout_q <= '0;
        else        aluout_q <= aluout_d;
    end

    assign aluout = aluout_q;

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed-vector bench for alu_core with hand-computed results.
module tb_alu_core;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] aluin1, aluin2;
    logic [2:0]  funct3;
    logic        funct7;
    logic [31:0] aluout;

    int n_tests = 0;
    int n_fail  = 0;

    alu_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .aluin1 (aluin1),
        .aluin2 (aluin2),
        .funct3 (funct3),
        .funct7 (funct7),
        .aluout (aluout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive at negedge, let one rising edge register it, sample 1 time unit later.
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f3, input logic f7, input logic [31:0] exp);
        @(negedge clk);
        aluin1 = a;
        aluin2 = b;
        funct3 = f3;
        funct7 = f7;
        @(posedge clk);
        #1;
        chk(tag, aluout, exp);
    endtask

    logic [31:0] sweep_exp [8];

    initial begin
        sweep_exp[0] = 32'h11;
        sweep_exp[1] = 32'h1C00;
        sweep_exp[2] = 32'h1;
        sweep_exp[3] = 32'h1;
        sweep_exp[4] = 32'hD;
        sweep_exp[5] = 32'h0;
        sweep_exp[6] = 32'hF;
        sweep_exp[7] = 32'h2;

        rst_n  = 1'b0;
        aluin1 = '0;
        aluin2 = '0;
        funct3 = F3_ADD;
        funct7 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", aluout, 32'h0);

        // Load a nonzero result, then assert reset mid-cycle.
        @(negedge clk);
        rst_n = 1'b1;
        op("pre_reset_add", 32'd7, 32'd10, F3_ADD, 1'b0, 32'h11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", aluout, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        op("post_reset_add0", 32'd0, 32'd0, F3_ADD, 1'b0, 32'h0);

        // funct7=0 sweep over every funct3.
        for (int i = 0; i < 8; i++)
            op($sformatf("sweep_f7_0_f3_%0d", i), 32'd7, 32'd10, 3'(i), 1'b0, sweep_exp[i]);

        // funct7=1: only SUB and SRA change.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] e;
            e = sweep_exp[i];
            if (i == 0) e = 32'hFFFF_FFFD;
            if (i == 5) e = 32'h0;
            op($sformatf("sweep_f7_1_f3_%0d", i), 32'd7, 32'd10, 3'(i), 1'b1, e);
        end

        // Signed vs unsigned handling of the MSB.
        op("slt_neg",  32'h8000_0000, 32'd1, F3_SLT,  1'b0, 32'h1);
        op("sltu_big", 32'h8000_0000, 32'd1, F3_SLTU, 1'b0, 32'h0);
        op("sra_neg",  32'h8000_0000, 32'd4, F3_SR,   1'b1, 32'hF800_0000);
        op("srl_neg",  32'h8000_0000, 32'd4, F3_SR,   1'b0, 32'h0800_0000);
        op("sll_out",  32'h8000_0000, 32'd4, F3_SLL,  1'b0, 32'h0);

        // Shift amount masking and zero shift.
        op("sll_mask",  32'd1,          32'h21, F3_SLL, 1'b0, 32'h2);
        op("sra_zero",  32'hDEAD_BEEF,  32'h20, F3_SR,  1'b1, 32'hDEAD_BEEF);
        op("srl_31",    32'h8000_0000,  32'h1F, F3_SR,  1'b0, 32'h1);
        op("sra_31",    32'h8000_0000,  32'h1F, F3_SR,  1'b1, 32'hFFFF_FFFF);

        // Carry out of bit 31 is discarded.
        op("add_wrap", 32'hFFFF_FFFF, 32'd1, F3_ADD, 1'b0, 32'h0);
        op("sub_wrap", 32'h0,         32'd1, F3_ADD, 1'b1, 32'hFFFF_FFFF);
        op("slt_eq",   32'hFFFF_FFFF, 32'hFFFF_FFFF, F3_SLT, 1'b0, 32'h0);

        // Unknown selects. Zero operands keep the expectation at 0 for any
        // decode a two-state simulator may resolve the unknowns to.
        op("f3_unknown", 32'd0, 32'd0, 3'bxxx, 1'b0, 32'h0);
        op("f7_unknown_and", 32'd7, 32'd10, F3_AND, 1'bx, 32'h2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
